// File: rtl/data_mem_port.sv
// Load/store executor for the MEM stage: runs one Avalon word transfer per request,
// builds byte-enables/replicated write data for stores and extends/merges load data.
module data_mem_port #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          is_load,
    input  logic          is_store,
    input  logic [2:0]    loadcontrol,
    input  logic [1:0]    store_size,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] store_data,
    input  logic [DW-1:0] rt_old,
    output logic          req_ready,
    output logic          done,
    output logic [DW-1:0] load_result,
    output logic          err,
    output logic [AW-1:0] avm_address,
    output logic          avm_read,
    output logic          avm_write,
    output logic [3:0]    avm_byteenable,
    output logic [DW-1:0] avm_writedata,
    input  logic [DW-1:0] avm_readdata,
    input  logic          avm_waitrequest
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0] LC_LB  = 3'b000;
    localparam logic [2:0] LC_LBU = 3'b001;
    localparam logic [2:0] LC_LH  = 3'b010;
    localparam logic [2:0] LC_LHU = 3'b011;
    localparam logic [2:0] LC_LW  = 3'b101;
    localparam logic [2:0] LC_LWL = 3'b110;
    localparam logic [2:0] LC_LWR = 3'b111;

    localparam logic [1:0] SS_SB = 2'b00;
    localparam logic [1:0] SS_SH = 2'b01;
    localparam logic [1:0] SS_SW = 2'b10;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    state_t      state_reg;
    logic [2:0]  lc_reg;
    logic [1:0]  o_reg;
    logic [31:0] rt_reg;

    logic [1:0]  o;
    logic        load_ok;
    logic        store_ok;
    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wd_next;

    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [5:0]  sh_o;
    logic [5:0]  sh_lwl;
    logic [5:0]  sh_lwl_mask;
    logic [31:0] load_value;

    assign o         = addr[1:0];
    assign req_ready = (state_reg == IDLE);

    always_comb begin
        load_ok = 1'b0;
        case (loadcontrol)
            LC_LB, LC_LBU, LC_LWL, LC_LWR: load_ok = 1'b1;
            LC_LH, LC_LHU:                 load_ok = ~o[0];
            LC_LW:                         load_ok = (o == 2'b00);
            default:                       load_ok = 1'b0;
        endcase
        store_ok = 1'b0;
        case (store_size)
            SS_SB:   store_ok = 1'b1;
            SS_SH:   store_ok = ~o[0];
            SS_SW:   store_ok = (o == 2'b00);
            default: store_ok = 1'b0;
        endcase
        legal = (is_load ^ is_store) && (is_load ? load_ok : store_ok);
    end

    always_comb begin
        be_next = 4'b1111;
        wd_next = store_data;
        case (store_size)
            SS_SB: begin
                be_next = 4'b0001 << o;
                wd_next = {4{store_data[7:0]}};
            end
            SS_SH: begin
                be_next = 4'b0011 << o;
                wd_next = {2{store_data[15:0]}};
            end
            default: begin
                be_next = 4'b1111;
                wd_next = store_data;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = avm_readdata[8*gi +: 8];
        end
    endgenerate

    // Shift amounts reach 32, so they are kept 6 bits wide; a full shift clears the word.
    assign sel_byte    = rd_byte[o_reg];
    assign sel_half    = o_reg[1] ? avm_readdata[31:16] : avm_readdata[15:0];
    assign sh_o        = {1'b0, o_reg, 3'b000};
    assign sh_lwl      = 6'd24 - sh_o;
    assign sh_lwl_mask = sh_o + 6'd8;

    always_comb begin
        load_value = avm_readdata;
        case (lc_reg)
            LC_LB:   load_value = {{24{sel_byte[7]}}, sel_byte};
            LC_LBU:  load_value = {24'h0, sel_byte};
            LC_LH:   load_value = {{16{sel_half[15]}}, sel_half};
            LC_LHU:  load_value = {16'h0, sel_half};
            LC_LWL:  load_value = (avm_readdata << sh_lwl) | (rt_reg & (ONES >> sh_lwl_mask));
            LC_LWR:  load_value = (avm_readdata >> sh_o) | (rt_reg & ~(ONES >> sh_o));
            default: load_value = avm_readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            lc_reg         <= 3'b000;
            o_reg          <= 2'b00;
            rt_reg         <= 32'h0;
            done           <= 1'b0;
            err            <= 1'b0;
            load_result    <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'b0000;
            avm_writedata  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (!legal) begin
                            err <= 1'b1;
                        end else begin
                            lc_reg      <= loadcontrol;
                            o_reg       <= o;
                            rt_reg      <= rt_old;
                            avm_address <= {addr[AW-1:2], 2'b00};
                            if (is_load) begin
                                avm_read       <= 1'b1;
                                avm_byteenable <= 4'b1111;
                                state_reg      <= RD;
                            end else begin
                                avm_write      <= 1'b1;
                                avm_byteenable <= be_next;
                                avm_writedata  <= wd_next;
                                state_reg      <= WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (!avm_waitrequest) begin
                        avm_read    <= 1'b0;
                        load_result <= load_value;
                        done        <= 1'b1;
                        state_reg   <= RESP;
                    end
                end
                WR: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= RESP;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed self-checking bench for data_mem_port: loads, stores, wait states, errors, reset.
module tb_data_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  loadcontrol;
    logic [1:0]  store_size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] rt_old;
    logic        req_ready;
    logic        done;
    logic [31:0] load_result;
    logic        err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_port #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .is_load(is_load),
        .is_store(is_store), .loadcontrol(loadcontrol), .store_size(store_size),
        .addr(addr), .store_data(store_data), .rt_old(rt_old), .req_ready(req_ready),
        .done(done), .load_result(load_result), .err(err), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns 1 ns after the accepting edge (cycle 1).
    task automatic drive_req(input logic ld, input logic st, input logic [2:0] lc,
                             input logic [1:0] ss, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rt);
        req_valid   = 1'b1;
        is_load     = ld;
        is_store    = st;
        loadcontrol = lc;
        store_size  = ss;
        addr        = a;
        store_data  = sd;
        rt_old      = rt;
        step();
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
    endtask

    // Zero-wait load; reports the result seen while done is high and whether done came.
    task automatic run_load(input logic [2:0] lc, input logic [31:0] a, input logic [31:0] rt,
                            input logic [31:0] m, output logic [31:0] res, output logic got);
        avm_waitrequest = 1'b0;
        avm_readdata    = m;
        drive_req(1'b1, 1'b0, lc, 2'b00, a, 32'h0, rt);
        got = 1'b0;
        res = 32'h0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) begin
                got = 1'b1;
                res = load_result;
            end else begin
                step();
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({req_ready, avm_read, avm_write, done, err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 10000", {req_ready, avm_read, avm_write, done, err});
        end
        n_cmp++;
        if ({load_result, avm_address, avm_writedata, avm_byteenable} !== 100'h0) begin
            n_bad++;
            $display("FAIL reset_data got %h/%h/%h/%h want 0", load_result, avm_address,
                     avm_writedata, avm_byteenable);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lb_timing();
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h80FF1234;
        drive_req(1'b1, 1'b0, 3'b000, 2'b00, 32'h1000_0003, 32'h0, 32'h0);
        n_cmp++;
        if ({avm_read, avm_write, avm_byteenable, req_ready, done} !== 8'b10_1111_00) begin
            n_bad++;
            $display("FAIL lb_cycle1 got rd=%b wr=%b be=%b rdy=%b done=%b want 1 0 1111 0 0",
                     avm_read, avm_write, avm_byteenable, req_ready, done);
        end
        n_cmp++;
        if (avm_address !== 32'h1000_0000) begin
            n_bad++;
            $display("FAIL lb_address got %h want 10000000", avm_address);
        end
        step();
        n_cmp++;
        if ({done, avm_read} !== 2'b10 || load_result !== 32'hFFFFFF80) begin
            n_bad++;
            $display("FAIL lb_cycle2 got done=%b rd=%b res=%h want 1 0 ffffff80",
                     done, avm_read, load_result);
        end
        step();
        n_cmp++;
        if ({done, req_ready} !== 2'b01 || load_result !== 32'hFFFFFF80) begin
            n_bad++;
            $display("FAIL lb_cycle3 got done=%b rdy=%b res=%h want 0 1 ffffff80",
                     done, req_ready, load_result);
        end
    endtask

    task automatic test_load_extract();
        logic [31:0] res;
        logic        got;
        logic [2:0]  lc_v  [7] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b110, 3'b111};
        logic [31:0] a_v   [7] = '{32'h3, 32'h2, 32'h2, 32'h1, 32'h1, 32'h7, 32'h4};
        logic [31:0] m_v   [7] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h44332211,
                                   32'h44332211, 32'h44332211, 32'h44332211};
        logic [31:0] exp_v [7] = '{32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h2211CCDD,
                                   32'hAA443322, 32'h44332211, 32'h44332211};
        for (int i = 0; i < 7; i++) begin
            run_load(lc_v[i], a_v[i], 32'hAABBCCDD, m_v[i], res, got);
            n_cmp++;
            if (!got || res !== exp_v[i]) begin
                n_bad++;
                $display("FAIL load_%0d lc=%b got done=%b res=%h want 1 %h",
                         i, lc_v[i], got, res, exp_v[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  lc_v [4] = '{3'b010, 3'b100, 3'b000, 3'b000};
        logic [1:0]  ss_v [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
        logic        ld_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        st_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] a_v  [4] = '{32'h1, 32'h0, 32'h2, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive_req(ld_v[i], st_v[i], lc_v[i], ss_v[i], a_v[i], 32'h55, 32'h0);
            n_cmp++;
            if ({err, req_ready, avm_read, avm_write} !== 4'b1100) begin
                n_bad++;
                $display("FAIL illegal_%0d got err=%b rdy=%b rd=%b wr=%b want 1 1 0 0",
                         i, err, req_ready, avm_read, avm_write);
            end
            step();
            n_cmp++;
            if ({err, done, avm_read, avm_write} !== 4'b0000) begin
                n_bad++;
                $display("FAIL illegal_after_%0d got err=%b done=%b rd=%b wr=%b want 0 0 0 0",
                         i, err, done, avm_read, avm_write);
            end
        end
    endtask

    task automatic test_store_wait();
        avm_waitrequest = 1'b1;
        drive_req(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_0041, 32'h000000AB, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) avm_waitrequest = 1'b0;
            n_cmp++;
            if ({avm_write, avm_read, done} !== 3'b100 || avm_byteenable !== 4'b0010 ||
                avm_writedata !== 32'hABABABAB || avm_address !== 32'h40) begin
                n_bad++;
                $display("FAIL sb_hold_c%0d got wr=%b rd=%b done=%b be=%b wd=%h a=%h want 1 0 0 0010 abababab 40",
                         c, avm_write, avm_read, done, avm_byteenable, avm_writedata, avm_address);
            end
            step();
        end
        n_cmp++;
        if ({done, avm_write} !== 2'b10) begin
            n_bad++;
            $display("FAIL sb_done_c5 got done=%b wr=%b want 1 0", done, avm_write);
        end
        step();
    endtask

    task automatic test_store_sizes();
        logic [1:0]  ss_v [2] = '{2'b01, 2'b10};
        logic [31:0] a_v  [2] = '{32'h2, 32'h8};
        logic [3:0]  be_v [2] = '{4'b1100, 4'b1111};
        logic [31:0] wd_v [2] = '{32'h56785678, 32'h12345678};
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b0, 1'b1, 3'b000, ss_v[i], a_v[i], 32'h12345678, 32'h0);
            n_cmp++;
            if (avm_write !== 1'b1 || avm_byteenable !== be_v[i] || avm_writedata !== wd_v[i]) begin
                n_bad++;
                $display("FAIL store_%0d got wr=%b be=%b wd=%h want 1 %b %h",
                         i, avm_write, avm_byteenable, avm_writedata, be_v[i], wd_v[i]);
            end
            step();
            n_cmp++;
            if (done !== 1'b1) begin
                n_bad++;
                $display("FAIL store_done_%0d got %b want 1", i, done);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        got;
        logic        saw_done;
        avm_waitrequest = 1'b1;
        drive_req(1'b1, 1'b0, 3'b101, 2'b00, 32'h0000_0020, 32'h0, 32'h0);
        n_cmp++;
        if (avm_read !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_read got %b want 1", avm_read);
        end
        step();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({avm_read, done, req_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL rstmid_drop got rd=%b done=%b rdy=%b want 0 0 1", avm_read, done, req_ready);
        end
        rst_n = 1'b1;
        avm_waitrequest = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_done = saw_done | done;
            step();
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_nodone got %b want 0", saw_done);
        end
        run_load(3'b101, 32'h0000_0024, 32'h0, 32'h12345678, res, got);
        n_cmp++;
        if (!got || res !== 32'h12345678) begin
            n_bad++;
            $display("FAIL rstmid_next got done=%b res=%h want 1 12345678", got, res);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        is_load         = 1'b0;
        is_store        = 1'b0;
        loadcontrol     = 3'b000;
        store_size      = 2'b00;
        addr            = 32'h0;
        store_data      = 32'h0;
        rt_old          = 32'h0;
        avm_readdata    = 32'h0;
        avm_waitrequest = 1'b0;
        test_reset();
        test_lb_timing();
        test_load_extract();
        test_illegal();
        test_store_wait();
        test_store_sizes();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
Memory-side executor for the load/store controls produced by the main decoder (loadcontrol, data_write). It accepts one load or store request per transaction from the datapath and runs a single Avalon-style word-bus transfer, honouring waitrequest. For stores it generates byte-enables and replicated write data; for loads it extracts and extends the result.
Sits between the datapath MEM stage and the data bus, and exposes ready/done signals so the CPU can stall.

Parameters:
AW, 32, byte address width
DW, 32, data width (fixed 32; other values unsupported)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request strobe from datapath
is_load  in  1  request is a load
is_store  in  1  request is a store (data_write)
loadcontrol  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 101 LW, 110 LWL, 111 LWR, 100 reserved
store_size  in  2  00 SB, 01 SH, 10 SW, 11 reserved
addr  in  AW  byte address
store_data  in  32  rt value for stores
rt_old  in  32  current rt, merge source for LWL/LWR
req_ready  out  1  high only in IDLE
done  out  1  one-cycle pulse: transfer complete
load_result  out  32  extended/merged load data, valid while done=1 and held after
err  out  1  one-cycle pulse: misaligned, reserved encoding, or is_load&is_store
avm_address  out  AW  word-aligned bus address {addr[AW-1:2],2'b00}
avm_read  out  1  bus read
avm_write  out  1  bus write
avm_byteenable  out  4  lane enables
avm_writedata  out  32  write data
avm_readdata  in  32  read data, valid in the cycle read is high and waitrequest low
avm_waitrequest  in  1  slave stall

Behaviour:
- Little-endian lanes: byte lane k holds bits [8k+7:8k]; o = addr[1:0].
- Reset (rst_n=0 at edge): state IDLE; avm_read, avm_write, done, err = 0; avm_byteenable, avm_address, avm_writedata, load_result = 0. Reset mid-transfer drops read/write at that edge, gives no done, and discards the captured request.
- FSM states IDLE, RD, WR, RESP.
- IDLE, req_valid=1: request is accepted at this edge.
  - Illegal request → err=1 next cycle, no bus access, stay IDLE. Illegal means: misaligned LW/SW (o≠0), misaligned LH/LHU/SH (o[0]=1), loadcontrol=100, store_size=11, is_load&is_store, or neither flag set.
  - Legal load → RD with avm_read=1, avm_byteenable=1111.
  - Legal store → WR with avm_write=1.
- SB: be = 0001<<o, wd = {4{store_data[7:0]}}.
- SH: be = 0011<<o, wd = {2{store_data[15:0]}}.
- SW: be = 1111, wd = store_data.
- RD/WR: address, byteenable, writedata and read/write are held stable while avm_waitrequest=1. On a cycle with waitrequest=0: drop read/write at the edge, go RESP. For RD, capture avm_readdata and compute load_result at that edge.
- RESP: done=1 for exactly one cycle, then → IDLE. req_valid is ignored outside IDLE.
- Minimum latency: accept at edge 0, bus strobe during cycle 1, done during cycle 2. Each waitrequest cycle adds one.
- Load extraction (m = captured word):
  - LB/LBU: byte m[8o+7:8o], sign/zero-extended.
  - LH/LHU: half m[16o[1]+15 : 16o[1]], sign/zero-extended.
  - LW: m.
  - LWL: (m << 8(3-o)) | (rt_old & (32'hFFFFFFFF >> 8(o+1))); at o=3 the result equals m.
  - LWR: (m >> 8o) | (rt_old & ~(32'hFFFFFFFF >> 8o)); at o=0 the result equals m.
- rt_old and store_data are sampled only at acceptance.
- LWL/LWR are never misaligned.

Test Plan:
- LB, o=3, readdata 0x80FF1234, waitrequest=0 → read in cycle 1, be=1111, address low bits 00; done in cycle 2, load_result=0xFFFFFF80. LBU with the same inputs → 0x00000080.
- LH, o=2, readdata 0x80FF1234 → 0xFFFF80FF. LHU → 0x000080FF. LH with o=1 → err pulse, avm_read never asserted.
- SB, o=1, store_data 0x000000AB, waitrequest high for 3 cycles → write held for 4 cycles, be=0010, wd=0xABABABAB stable throughout; done in cycle 5.
- LWL, o=1, mem 0x44332211, rt_old 0xAABBCCDD → 0x2211CCDD. LWR, o=1, same inputs → 0xAA443322.
- LW with waitrequest held high, rst_n=0 in cycle 2 → avm_read=0 after that edge, no done. Next request is accepted normally.
- req_valid with is_load=is_store=1 → err=1 for one cycle, req_ready stays 1, no bus activity.
